// File: rtl/decode_issue_queue.sv
// Decode/issue queue: DEPTH-entry instruction FIFO feeding a registered RV32 decode stage.
// Define M_EXT_EN to enable M-extension decode and the multiply/divide busy stall.
module decode_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_alu_src,
    output logic        out_mem_write,
    output logic        out_wb_load,
    output logic        out_wb_reg_file,
    output logic        out_invalid,
    output logic        out_m_type,
    output logic [2:0]  out_load_type,
    output logic [1:0]  out_store_type,
    output logic        m_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] LOAD_LB   = 3'd0;
    localparam logic [2:0] LOAD_LH   = 3'd1;
    localparam logic [2:0] LOAD_LW   = 3'd2;
    localparam logic [2:0] LOAD_LBU  = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_DEF  = 3'd7;
    localparam logic [1:0] STORE_SB  = 2'd0;
    localparam logic [1:0] STORE_SH  = 2'd1;
    localparam logic [1:0] STORE_SW  = 2'd2;
    localparam logic [1:0] STORE_DEF = 2'd3;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic       wb_load;
        logic       wb_reg_file;
        logic       invalid;
        logic       m_type;
        logic [2:0] load_type;
        logic [1:0] store_type;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{
        alu_src: 1'b0, mem_write: 1'b0, wb_load: 1'b0, wb_reg_file: 1'b0,
        invalid: 1'b0, m_type: 1'b0, load_type: LOAD_DEF, store_type: STORE_DEF
    };

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t      c;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = instr[6:0];
        f3 = instr[14:12];
        f7 = instr[31:25];
        c  = CTRL_RST;
        case (op)
            OP_R: begin
                c.wb_reg_file = 1'b1;
                if (f7 == 7'b0000001) begin
`ifdef M_EXT_EN
                    c.m_type = 1'b1;
`else
                    c.invalid = 1'b1;
`endif
                end else if (f7 != 7'b0000000 && f7 != 7'b0100000) begin
                    c.invalid = 1'b1;
                end
            end
            OP_I, OP_LUI, OP_AUIPC, OP_JALR: begin
                c.alu_src     = 1'b1;
                c.wb_reg_file = 1'b1;
            end
            OP_LOAD: begin
                c.alu_src     = 1'b1;
                c.wb_reg_file = 1'b1;
                c.wb_load     = 1'b1;
                case (f3)
                    3'b000:  c.load_type = LOAD_LB;
                    3'b001:  c.load_type = LOAD_LH;
                    3'b010:  c.load_type = LOAD_LW;
                    3'b100:  c.load_type = LOAD_LBU;
                    3'b101:  c.load_type = LOAD_LHU;
                    default: c.load_type = LOAD_DEF;
                endcase
            end
            OP_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                case (f3)
                    3'b000:  c.store_type = STORE_SB;
                    3'b001:  c.store_type = STORE_SH;
                    3'b010:  c.store_type = STORE_SW;
                    default: c.store_type = STORE_DEF;
                endcase
            end
            OP_JAL:    c.wb_reg_file = 1'b1;
            OP_BRANCH: ;
            default:   c.invalid = 1'b1;
        endcase
        // An invalid bundle is still issued, but must not write any architectural state.
        if (c.invalid) begin
            c.wb_reg_file = 1'b0;
            c.wb_load     = 1'b0;
            c.mem_write   = 1'b0;
            c.load_type   = LOAD_DEF;
            c.store_type  = STORE_DEF;
        end
        return c;
    endfunction

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic [31:0]      out_instr_q, out_instr_d;
    ctrl_t            out_ctrl_q, out_ctrl_d;

    logic             push;
    logic             load;
    logic [31:0]      head_instr;
    ctrl_t            head_ctrl;

    assign head_instr = instr_mem[rd_ptr_q];
    assign head_ctrl  = decode(head_instr);
    assign in_ready   = (count_q < CNT_W'(DEPTH));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push     = in_valid && in_ready && !flush;
        load     = (count_q != '0) && !m_busy && (!out_valid_q || out_ready) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, load})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_ctrl_d  = out_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_mem[rd_ptr_q];
            out_instr_d = head_instr;
            out_ctrl_d  = head_ctrl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: storage array is deliberately not reset; count_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_ctrl_q  <= CTRL_RST;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_ctrl_q  <= out_ctrl_d;
        end
    end

`ifdef M_EXT_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int BUSY_W  = $clog2(MAX_LAT + 1);

    logic [BUSY_W-1:0] busy_q, busy_d;

    // The counter is armed when an M-type bundle enters the output register, so the
    // following instruction waits the full unit latency before it can be issued.
    always_comb begin
        busy_d = busy_q;
        if (load && head_ctrl.m_type) begin
            busy_d = head_instr[14] ? BUSY_W'(DIV_LAT - 1) : BUSY_W'(MUL_LAT - 1);
        end else if (busy_q != '0) begin
            busy_d = busy_q - BUSY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign m_busy = (busy_q != '0);
`else
    assign m_busy = 1'b0;
`endif

    assign out_valid       = out_valid_q;
    assign out_pc          = out_pc_q;
    assign out_instr       = out_instr_q;
    assign out_alu_src     = out_ctrl_q.alu_src;
    assign out_mem_write   = out_ctrl_q.mem_write;
    assign out_wb_load     = out_ctrl_q.wb_load;
    assign out_wb_reg_file = out_ctrl_q.wb_reg_file;
    assign out_invalid     = out_ctrl_q.invalid;
    assign out_m_type      = out_ctrl_q.m_type;
    assign out_load_type   = out_ctrl_q.load_type;
    assign out_store_type  = out_ctrl_q.store_type;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: queue-level reference model checked every cycle plus directed literal checks.
// Honours M_EXT_EN the same way as the design.
module tb_decode_issue_queue;

    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;
`ifdef M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [2:0] LOAD_LB = 3'd0, LOAD_LH = 3'd1, LOAD_LW = 3'd2;
    localparam logic [2:0] LOAD_LBU = 3'd3, LOAD_LHU = 3'd4, LOAD_DEF = 3'd7;
    localparam logic [1:0] STORE_SB = 2'd0, STORE_SH = 2'd1, STORE_SW = 2'd2, STORE_DEF = 2'd3;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_ADDI = 32'h00108093;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;
    localparam logic [31:0] I_MUL  = 32'h02208033;
    localparam logic [31:0] I_LBU  = 32'h0000C083;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr, out_pc;
    logic        out_alu_src, out_mem_write, out_wb_load, out_wb_reg_file, out_invalid, out_m_type;
    logic [2:0]  out_load_type;
    logic [1:0]  out_store_type;
    logic        m_busy;

    decode_issue_queue #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_alu_src(out_alu_src), .out_mem_write(out_mem_write), .out_wb_load(out_wb_load),
        .out_wb_reg_file(out_wb_reg_file), .out_invalid(out_invalid), .out_m_type(out_m_type),
        .out_load_type(out_load_type), .out_store_type(out_store_type), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected control bits {alu_src, mem_write, wb_load, wb_reg_file, invalid, m_type, load_type, store_type}
    function automatic logic [10:0] exp_ctrl(input logic [31:0] ins);
        logic [6:0] op, f7;
        logic [2:0] f3, lt;
        logic [1:0] st;
        logic       is_r, known, mul, inv, alu, wb, wl, mw;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        is_r  = (op == 7'b0110011);
        known = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                           7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};
        mul   = is_r && (f7 == 7'b0000001) && M_EN;
        inv   = !known || (is_r && !((f7 inside {7'b0000000, 7'b0100000}) || mul));
        alu   = op inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1100111};
        wb    = !inv && (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                    7'b0010111, 7'b1101111, 7'b1100111});
        wl    = !inv && (op == 7'b0000011);
        mw    = !inv && (op == 7'b0100011);
        lt    = LOAD_DEF;
        st    = STORE_DEF;
        if (wl) begin
            case (f3)
                3'b000: lt = LOAD_LB;
                3'b001: lt = LOAD_LH;
                3'b010: lt = LOAD_LW;
                3'b100: lt = LOAD_LBU;
                3'b101: lt = LOAD_LHU;
                default: lt = LOAD_DEF;
            endcase
        end
        if (mw) begin
            case (f3)
                3'b000: st = STORE_SB;
                3'b001: st = STORE_SH;
                3'b010: st = STORE_SW;
                default: st = STORE_DEF;
            endcase
        end
        return {alu, mw, wl, wb, inv, mul, lt, st};
    endfunction

    // Reference model: a queue of waiting words plus one output slot and a busy countdown.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t      mq[$];
    entry_t      hd;
    bit          m_ov = 1'b0;
    logic [31:0] m_pc = '0, m_instr = '0;
    int          m_busy_cnt = 0;
    bit          mdl_busy, mdl_room, mdl_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ov = 1'b0;
            m_pc = '0;
            m_instr = '0;
            m_busy_cnt = 0;
        end else begin
            mdl_busy = (m_busy_cnt != 0);
            mdl_room = (mq.size() < DEPTH);
            mdl_take = !flush && (mq.size() != 0) && !mdl_busy && (!m_ov || out_ready);
            if (mdl_busy) m_busy_cnt--;
            if (flush) begin
                mq.delete();
                m_ov = 1'b0;
            end else begin
                if (mdl_take) begin
                    hd = mq.pop_front();
                    m_ov = 1'b1;
                    m_pc = hd.pc;
                    m_instr = hd.instr;
                    if (exp_ctrl(hd.instr) & 11'b00000100000)
                        m_busy_cnt = hd.instr[14] ? DIV_LAT - 1 : MUL_LAT - 1;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
                if (in_valid && mdl_room) mq.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", out_valid, m_ov);
        check("in_ready", in_ready, mq.size() < DEPTH);
        check("m_busy", m_busy, m_busy_cnt != 0);
        if (m_ov) begin
            check("out_pc", out_pc, m_pc);
            check("out_instr", out_instr, m_instr);
            check("out_ctrl", {out_alu_src, out_mem_write, out_wb_load, out_wb_reg_file, out_invalid,
                               out_m_type, out_load_type, out_store_type}, exp_ctrl(m_instr));
        end
    end

    int dead_seen = 0;
    always @(posedge clk) if (rst_n && out_valid && out_ready && out_pc == 32'hDEAD0) dead_seen++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; presents one word for exactly one cycle.
    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick(1);
        in_valid = 1'b0;
    endtask

    logic [31:0] vec [16] = '{32'h0020A023, 32'h00208023, 32'h0020B023, 32'h00009083,
                              32'h0000A083, 32'h0000D083, 32'h0000B083, 32'h123450B7,
                              32'h00000097, 32'h0000006F, 32'h000080E7, 32'h00208063,
                              32'h40208033, 32'h04208033, I_ADDI, I_MUL};

    int accepted, busy_cycles, last_busy, div_cycle, add_cycle;
    logic div_inv, div_m;

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_m_busy", m_busy, 1'b0);
        check("rst_load_type", out_load_type, LOAD_DEF);
        check("rst_store_type", out_store_type, STORE_DEF);
        check("rst_out_pc", out_pc, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // ADD: visible two edges after being presented
        push(32'h100, I_ADD);
        @(negedge clk);
        check("add_not_yet", out_valid, 1'b0);
        @(negedge clk);
        check("add_valid", out_valid, 1'b1);
        check("add_wb_reg_file", out_wb_reg_file, 1'b1);
        check("add_alu_src", out_alu_src, 1'b0);
        check("add_invalid", out_invalid, 1'b0);
        tick(1);

        push(32'h110, I_LBU);
        @(posedge clk); @(negedge clk);
        check("lbu_load_type", out_load_type, LOAD_LBU);
        check("lbu_wb_load", out_wb_load, 1'b1);
        check("lbu_alu_src", out_alu_src, 1'b1);
        tick(1);

        push(32'h120, I_BAD);
        @(posedge clk); @(negedge clk);
        check("bad_invalid", out_invalid, 1'b1);
        check("bad_wb_reg_file", out_wb_reg_file, 1'b0);
        check("bad_valid", out_valid, 1'b1);
        tick(1);

        for (int i = 0; i < 16; i++) push(32'h1000 + 32'(i) * 4, vec[i]);
        tick(8);

        // Back-pressure: DEPTH queued plus one held in the output register
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h200 + 32'(i) * 4;
            in_instr = I_ADDI;
            @(negedge clk);
            if (in_ready) accepted++;
            tick(1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", accepted, 5);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_held_pc", out_pc, 32'h200);
        check("bp_held_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick(8);

        // Flush with a simultaneous push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i) * 4, I_ADD);
        in_valid = 1'b1;
        in_pc    = 32'hDEAD0;
        in_instr = I_ADD;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick(6);
        check("flush_dead_seen", dead_seen, 0);
        check("flush_drained", out_valid, 1'b0);

        // Asynchronous reset with work in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(i) * 4, I_ADD);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_m_busy", m_busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(1);
        push(32'h500, I_ADD);
        @(posedge clk); @(negedge clk);
        check("post_rst_pc", out_pc, 32'h500);
        check("post_rst_valid", out_valid, 1'b1);
        tick(1);

        // DIV followed by ADD
        push(32'h600, I_DIV);
        push(32'h604, I_ADD);
        busy_cycles = 0; last_busy = -1; div_cycle = -1; add_cycle = -1;
        div_inv = 1'bx; div_m = 1'bx;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (m_busy) begin busy_cycles++; last_busy = k; end
            if (out_valid && out_pc == 32'h600 && div_cycle < 0) begin
                div_cycle = k; div_inv = out_invalid; div_m = out_m_type;
            end
            if (out_valid && out_pc == 32'h604 && add_cycle < 0) add_cycle = k;
        end
        tick(1);
        if (M_EN) begin
            check("div_busy_cycles", busy_cycles, 31);
            check("div_add_after_busy", add_cycle, last_busy + 1);
            check("div_m_type", div_m, 1'b1);
            check("div_invalid", div_inv, 1'b0);
        end else begin
            check("div_busy_cycles", busy_cycles, 0);
            check("div_add_no_stall", add_cycle, div_cycle + 1);
            check("div_invalid", div_inv, 1'b1);
            check("div_m_type", div_m, 1'b0);
        end

        push(32'h700, I_MUL);
        push(32'h704, I_ADD);
        tick(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
